// File: rtl/full_comparator_pkg.sv
// Shared types and helpers for the cascadable magnitude comparator.
package full_comparator_pkg;

   // Running state of the MSB-to-LSB compare chain.
   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_LT = 2'd1,
      CMP_GT = 2'd2
   } cmp_state_t;

   // Turn the cascade inputs from a more-significant stage into a chain seed.
   // gt_in wins over lt_in; an all-zero cascade means "upper part equal",
   // which is how a standalone instance is used.
   function automatic cmp_state_t cascade_decode(
      input logic lt_in,
      input logic gt_in,
      input logic eq_in
   );
      cmp_state_t seed;
      if (gt_in) begin
         seed = CMP_GT;
      end else if (lt_in) begin
         seed = CMP_LT;
      end else if (eq_in) begin
         seed = CMP_EQ;
      end else begin
         seed = CMP_EQ;
      end
      return seed;
   endfunction

endpackage

// File: rtl/full_comparator_slice.sv
// One bit of the compare chain: refines an "equal so far" state with the
// local bit pair, and passes an already-decided state straight through.
module compare_slice
   import full_comparator_pkg::*;
(
   input  cmp_state_t state_in,
   input  logic       a_bit,
   input  logic       b_bit,
   input  logic       swap,
   output cmp_state_t state_out
);

   logic effA_s;
   logic effB_s;

   // Swapping operands on the sign bit makes a set sign bit read as "smaller".
   assign effA_s = swap ? b_bit : a_bit;
   assign effB_s = swap ? a_bit : b_bit;

   // Decide this bit only while the more-significant bits are still equal.
   always_comb begin
      state_out = CMP_EQ;
      case (state_in)
         CMP_EQ: begin
            if (effA_s & ~effB_s) begin
               state_out = CMP_GT;
            end else if (~effA_s & effB_s) begin
               state_out = CMP_LT;
            end else begin
               state_out = CMP_EQ;
            end
         end
         CMP_LT:  state_out = CMP_LT;
         CMP_GT:  state_out = CMP_GT;
         default: state_out = CMP_EQ;
      endcase
   end

endmodule

// File: rtl/full_comparator.sv
// Registered, cascadable WIDTH-bit magnitude comparator (unsigned or signed).
// Result and valid are registered; there is no input-to-output path.
module full_comparator
   import full_comparator_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             lt_in,
   input  logic             gt_in,
   input  logic             eq_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   // chainState_s[WIDTH] is the cascade seed, chainState_s[0] the final verdict.
   cmp_state_t chainState_s [WIDTH:0];

   logic nextLt_s;
   logic nextGt_s;
   logic nextEq_s;

   logic validReg_r;
   logic ltReg_r;
   logic gtReg_r;
   logic eqReg_r;

   assign chainState_s[WIDTH] = cascade_decode(lt_in, gt_in, eq_in);

   for (genvar i = 0; i < WIDTH; i++) begin : gSlice
      localparam bit swapMsb = SIGNED && (i == WIDTH - 1);

      compare_slice uSlice (
         .state_in  (chainState_s[i+1]),
         .a_bit     (a[i]),
         .b_bit     (b[i]),
         .swap      (swapMsb),
         .state_out (chainState_s[i])
      );
   end

   // Decode the final chain state into one-hot lt/gt/eq.
   always_comb begin
      nextLt_s = 1'b0;
      nextGt_s = 1'b0;
      nextEq_s = 1'b0;
      case (chainState_s[0])
         CMP_LT:  nextLt_s = 1'b1;
         CMP_GT:  nextGt_s = 1'b1;
         CMP_EQ:  nextEq_s = 1'b1;
         default: nextEq_s = 1'b1;
      endcase
   end

   // Valid follows in_valid every cycle; the result only loads on valid input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         validReg_r <= 1'b0;
         ltReg_r    <= 1'b0;
         gtReg_r    <= 1'b0;
         eqReg_r    <= 1'b0;
      end else begin
         validReg_r <= in_valid;
         if (in_valid) begin
            ltReg_r <= nextLt_s;
            gtReg_r <= nextGt_s;
            eqReg_r <= nextEq_s;
         end
      end
   end

   assign out_valid = validReg_r;
   assign lt        = ltReg_r;
   assign gt        = gtReg_r;
   assign eq        = eqReg_r;

endmodule

// File: tb/tb_full_comparator.sv
// Scoreboard bench: three comparator instances (1-bit unsigned, 8-bit
// unsigned, 8-bit signed) fed the same stimulus; a behavioural model pushes
// the expected {lt,gt,eq} per instance when a compare is issued.
module tb_full_comparator;

   typedef struct {
      logic       l;
      logic       g;
      logic       e;
      logic [7:0] a;
      logic [7:0] b;
   } stim_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       lt_in;
   logic       gt_in;
   logic       eq_in;
   logic [0:0] a1;
   logic [0:0] b1;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       ov1, lt1, gt1, eq1;
   logic       ov8u, lt8u, gt8u, eq8u;
   logic       ov8s, lt8s, gt8s, eq8s;

   logic [2:0] q1  [$];
   logic [2:0] q8u [$];
   logic [2:0] q8s [$];

   int nChecks = 0;
   int nPass   = 0;

   full_comparator #(.WIDTH(1), .SIGNED(1'b0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in),
      .a(a1), .b(b1),
      .out_valid(ov1), .lt(lt1), .gt(gt1), .eq(eq1)
   );

   full_comparator #(.WIDTH(8), .SIGNED(1'b0)) dut8u (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in),
      .a(a8), .b(b8),
      .out_valid(ov8u), .lt(lt8u), .gt(gt8u), .eq(eq8u)
   );

   full_comparator #(.WIDTH(8), .SIGNED(1'b1)) dut8s (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in),
      .a(a8), .b(b8),
      .out_valid(ov8s), .lt(lt8s), .gt(gt8s), .eq(eq8s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: integer comparison of the low w bits, {lt,gt,eq}.
   function automatic logic [2:0] model(input int w, input bit sgn, input stim_t s);
      longint va;
      longint vb;
      longint span;
      if (s.g) return 3'b010;
      if (s.l) return 3'b100;
      span = longint'(1) << w;
      va = longint'(s.a) % span;
      vb = longint'(s.b) % span;
      if (sgn && va >= span / 2) va = va - span;
      if (sgn && vb >= span / 2) vb = vb - span;
      if (va < vb) return 3'b100;
      if (va > vb) return 3'b010;
      return 3'b001;
   endfunction

   task automatic issue(input stim_t s);
      in_valid = 1'b1;
      lt_in    = s.l;
      gt_in    = s.g;
      eq_in    = s.e;
      a8       = s.a;
      b8       = s.b;
      a1       = s.a[0:0];
      b1       = s.b[0:0];
      q1.push_back(model(1, 1'b0, s));
      q8u.push_back(model(8, 1'b0, s));
      q8s.push_back(model(8, 1'b1, s));
   endtask

   task automatic test_reset;
      #2;
      nChecks++;
      if ({ov1, lt1, gt1, eq1, ov8u, lt8u, gt8u, eq8u, ov8s, lt8s, gt8s, eq8s} !== 12'h000) begin
         $display("FAIL reset_state got %b want 000000000000",
                  {ov1, lt1, gt1, eq1, ov8u, lt8u, gt8u, eq8u, ov8s, lt8s, gt8s, eq8s});
      end else nPass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_cascade_precedence;
      stim_t      s [4];
      logic [2:0] e;
      s[0] = '{l: 1'b1, g: 1'b0, e: 1'b0, a: 8'h01, b: 8'h00};
      s[1] = '{l: 1'b0, g: 1'b1, e: 1'b0, a: 8'h00, b: 8'h01};
      s[2] = '{l: 1'b1, g: 1'b1, e: 1'b0, a: 8'h10, b: 8'h20};
      s[3] = '{l: 1'b0, g: 1'b0, e: 1'b0, a: 8'h10, b: 8'h20};
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            e = q1.pop_front(); nChecks++;
            if ({ov1, lt1, gt1, eq1} !== {1'b1, e}) begin
               $display("FAIL casc_w1[%0d] got %b want %b", k - 1, {ov1, lt1, gt1, eq1}, {1'b1, e});
            end else nPass++;
            e = q8u.pop_front(); nChecks++;
            if ({ov8u, lt8u, gt8u, eq8u} !== {1'b1, e}) begin
               $display("FAIL casc_w8u[%0d] got %b want %b", k - 1, {ov8u, lt8u, gt8u, eq8u}, {1'b1, e});
            end else nPass++;
            e = q8s.pop_front(); nChecks++;
            if ({ov8s, lt8s, gt8s, eq8s} !== {1'b1, e}) begin
               $display("FAIL casc_w8s[%0d] got %b want %b", k - 1, {ov8s, lt8s, gt8s, eq8s}, {1'b1, e});
            end else nPass++;
         end
         if (k < 4) issue(s[k]); else in_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back_1bit;
      stim_t      s [4];
      logic [2:0] e;
      s[0] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h00, b: 8'h00};
      s[1] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h01, b: 8'h00};
      s[2] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h00, b: 8'h01};
      s[3] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h01, b: 8'h01};
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            e = q1.pop_front(); nChecks++;
            if ({ov1, lt1, gt1, eq1} !== {1'b1, e}) begin
               $display("FAIL b2b_w1[%0d] got %b want %b", k - 1, {ov1, lt1, gt1, eq1}, {1'b1, e});
            end else nPass++;
            e = q8u.pop_front(); nChecks++;
            if ({ov8u, lt8u, gt8u, eq8u} !== {1'b1, e}) begin
               $display("FAIL b2b_w8u[%0d] got %b want %b", k - 1, {ov8u, lt8u, gt8u, eq8u}, {1'b1, e});
            end else nPass++;
            e = q8s.pop_front(); nChecks++;
            if ({ov8s, lt8s, gt8s, eq8s} !== {1'b1, e}) begin
               $display("FAIL b2b_w8s[%0d] got %b want %b", k - 1, {ov8s, lt8s, gt8s, eq8s}, {1'b1, e});
            end else nPass++;
         end
         if (k < 4) issue(s[k]); else in_valid = 1'b0;
      end
   endtask

   task automatic test_compare8_and_hold;
      stim_t      s [4];
      logic [2:0] e;
      logic [2:0] last8u;
      last8u = 3'b000;
      s[0] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h80, b: 8'h7F};
      s[1] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h3C, b: 8'h3C};
      s[2] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h00, b: 8'hFF};
      s[3] = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'hFF, b: 8'hFE};
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            e = q1.pop_front(); nChecks++;
            if ({ov1, lt1, gt1, eq1} !== {1'b1, e}) begin
               $display("FAIL cmp8_w1[%0d] got %b want %b", k - 1, {ov1, lt1, gt1, eq1}, {1'b1, e});
            end else nPass++;
            e = q8u.pop_front(); nChecks++;
            last8u = e;
            if ({ov8u, lt8u, gt8u, eq8u} !== {1'b1, e}) begin
               $display("FAIL cmp8_w8u[%0d] got %b want %b", k - 1, {ov8u, lt8u, gt8u, eq8u}, {1'b1, e});
            end else nPass++;
            e = q8s.pop_front(); nChecks++;
            if ({ov8s, lt8s, gt8s, eq8s} !== {1'b1, e}) begin
               $display("FAIL cmp8_w8s[%0d] got %b want %b", k - 1, {ov8s, lt8s, gt8s, eq8s}, {1'b1, e});
            end else nPass++;
         end
         if (k < 4) issue(s[k]); else in_valid = 1'b0;
      end
      // Change operands while idle: result must hold, valid must drop.
      a8 = 8'h00;
      b8 = 8'h00;
      @(negedge clk);
      nChecks++;
      if ({ov8u, lt8u, gt8u, eq8u} !== {1'b0, last8u}) begin
         $display("FAIL hold_w8u got %b want %b", {ov8u, lt8u, gt8u, eq8u}, {1'b0, last8u});
      end else nPass++;
   endtask

   task automatic test_reset_hold;
      stim_t s;
      s = '{l: 1'b0, g: 1'b0, e: 1'b1, a: 8'h3C, b: 8'h01};
      @(negedge clk);
      issue(s);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      nChecks++;
      if ({ov1, ov8u, ov8s} !== 3'b111) begin
         $display("FAIL pre_reset_valid got %b want 111", {ov1, ov8u, ov8s});
      end else nPass++;
      #1;
      rst = 1'b1;
      #1;
      nChecks++;
      if ({ov1, lt1, gt1, eq1, ov8u, lt8u, gt8u, eq8u, ov8s, lt8s, gt8s, eq8s} !== 12'h000) begin
         $display("FAIL async_reset got %b want 000000000000",
                  {ov1, lt1, gt1, eq1, ov8u, lt8u, gt8u, eq8u, ov8s, lt8s, gt8s, eq8s});
      end else nPass++;
      q1.delete();
      q8u.delete();
      q8s.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         nChecks++;
         if ({ov1, lt1, gt1, eq1, ov8u, lt8u, gt8u, eq8u, ov8s, lt8s, gt8s, eq8s} !== 12'h000) begin
            $display("FAIL idle_after_reset[%0d] got %b want 000000000000", k,
                     {ov1, lt1, gt1, eq1, ov8u, lt8u, gt8u, eq8u, ov8s, lt8s, gt8s, eq8s});
         end else nPass++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      lt_in    = 1'b0;
      gt_in    = 1'b0;
      eq_in    = 1'b0;
      a1       = 1'b0;
      b1       = 1'b0;
      a8       = 8'h00;
      b8       = 8'h00;
      test_reset();
      test_cascade_precedence();
      test_back_to_back_1bit();
      test_compare8_and_hold();
      test_reset_hold();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/full_comparator.md
# full_comparator

Registered, cascadable magnitude comparator for two unsigned or two's-complement WIDTH-bit operands. A ripple chain of 1-bit compare slices runs from MSB to LSB and is seeded by cascade inputs from a more-significant stage, so wider comparisons can be built by chaining instances. The lt/gt/eq result is captured in an output register with a one-cycle valid pipeline. It sits in datapath control logic: sort, min/max and threshold-detect units.

## Interface
- WIDTH, 8: operand width in bits; legal range is 1 or greater.
- SIGNED, 0: 0 compares a and b as unsigned; 1 compares them as two's complement.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b and the cascade inputs in this cycle.
- lt_in  input  1  cascade from the more-significant stage: upper part already decided "a < b".
- gt_in  input  1  cascade: upper part already decided "a > b".
- eq_in  input  1  cascade: upper part equal, so the local bits decide.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  registered copy of in_valid.
- lt  output  1  registered result: a < b, or upper part less.
- gt  output  1  registered result: a > b, or upper part greater.
- eq  output  1  registered result: fully equal.

## Operation
- Cascade decode, in priority order:
  - gt_in=1 forces result gt, regardless of the other cascade inputs.
  - else lt_in=1 forces result lt.
  - else (eq_in=1, or all three cascade inputs 0) the local bits are compared.
  - All-zero cascade is treated as "equal"; this is the standalone-use case.
- Slice function, per bit i, evaluated from bit WIDTH-1 down to bit 0:
  - If the incoming state is lt or gt, pass it through unchanged.
  - If the incoming state is eq: a[i]&~b[i] gives gt, ~a[i]&b[i] gives lt, otherwise stay eq.
- SIGNED=1: at the MSB slice only, the roles of a and b are swapped, since a 1 in the sign bit means a smaller value.
- The final slice state drives the next-state of lt/gt/eq. Exactly one of lt/gt/eq is 1 whenever out_valid=1.
- When in_valid=0, the lt/gt/eq registers hold their previous values; only out_valid updates.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Timing
- Latency is 1 cycle: inputs sampled at edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1.
- No backpressure; a new comparison can be issued every cycle.
- Reset, asynchronous: out_valid=0, lt=0, gt=0, eq=0 immediately on rst assertion. The first result appears one edge after in_valid is sampled high with rst low.
- Reset asserted mid-stream drops any in-flight result; there is no replay.
- Combinational critical path is WIDTH slices deep. No retiming is required for WIDTH ≤ 32 at the target clock.

## Structure
- Shared package full_comparator_pkg holds:
  - enum cmp_state_t {CMP_EQ, CMP_LT, CMP_GT};
  - function cascade_decode(lt_in, gt_in, eq_in) returning cmp_state_t.
- Sub-module compare_slice: purely combinational 1-bit cell.
  - Ports: state_in (cmp_state_t), a_bit, b_bit, swap, state_out.
  - Instantiated WIDTH times with a generate loop; swap is tied to 1 only for the MSB when SIGNED=1.
- The top level holds only the slice chain, the output register and the valid register.

## Test plan
- WIDTH=1, SIGNED=0 cascade precedence:
  - lt_in=1, gt_in=0, eq_in=0, a=1, b=0 → lt=1, gt=0, eq=0 one cycle later.
  - lt_in=0, gt_in=1, eq_in=0, a=0, b=1 → gt=1.
- WIDTH=1, SIGNED=0 with eq_in=1 and the other cascade inputs 0: apply a/b = 0/0, 1/0, 0/1, 1/1 back-to-back with in_valid=1. Required results on consecutive cycles: eq, gt, lt, eq.
- WIDTH=8, SIGNED=0, eq_in=1:
  - a=0x80, b=0x7F → gt.
  - a=0x3C, b=0x3C → eq.
  - a=0x00, b=0xFF → lt.
- WIDTH=8, SIGNED=1, eq_in=1:
  - a=0x80 (−128), b=0x7F → lt.
  - a=0xFF (−1), b=0xFE (−2) → gt.
- Invalid cascade inputs, WIDTH=8, a=0x10, b=0x20:
  - lt_in=gt_in=1 → gt (gt_in priority).
  - All three cascade inputs 0 → lt (local compare).
- Reset and hold:
  - Assert rst asynchronously between edges while out_valid=1 → all outputs 0 immediately.
  - After release, in_valid=0 for 3 cycles → out_valid stays 0 and lt/gt/eq stay 0.
